fetch_pc_gen: RTL and testbench
===============================

// Module: fetch_pc_gen
// PURPOSE
//  Fetch-stage PC generator sitting directly downstream of the branch predictor (BTB + PHT) inside CPUTop.
//  Each cycle it presents a PC to instruction memory and the predictor, then picks the next PC from the
//  predictor's hit/taken/target answer or PC+4. It records per-fetch prediction metadata in a small FIFO,
//  which EX drains to resolve branches and update the BTB/PHT. EX mispredict redirects flush the FIFO.
// PARAMETERS
//  XLEN       32     address/PC width
//  RESET_PC   32'h0  PC loaded on reset
//  FIFO_DEPTH 4      in-flight prediction metadata entries (power of 2, >=2)
//  PHT_IDX_W  8      PHT index width (256-entry PHT)
// PORTS
//  sysclk          in   1          clock, rising edge
//  nrst            in   1          asynchronous active-low reset
//  imem_addr       out  XLEN       current fetch PC (also drives predictor lookup)
//  imem_valid      out  1          fetch request valid
//  imem_ready      in   1          imem accepts request this cycle
//  stall           in   1          decode backpressure; hold PC
//  pred_hit        in   1          BTB hit for imem_addr (combinational, same cycle)
//  pred_taken      in   1          PHT predicts taken
//  pred_target     in   XLEN       BTB target
//  pred_idx        in   PHT_IDX_W  PHT index used for this lookup
//  redirect_valid  in   1          EX mispredict / jump resolution
//  redirect_pc     in   XLEN       corrected PC
//  meta_valid      out  1          FIFO head valid
//  meta_ready      in   1          EX consumes head
//  meta_pc         out  XLEN       head: fetched PC
//  meta_taken      out  1          head: predicted taken (hit & taken)
//  meta_target     out  XLEN       head: predicted next PC
//  meta_idx        out  PHT_IDX_W  head: PHT index
// BEHAVIOUR
//  Reset (async, nrst=0): pc=RESET_PC, imem_valid=0, meta_valid=0, FIFO count=0, state=IDLE; meta_* data=0.
//  States: IDLE -> RUN (unconditionally, 1 cycle after nrst deasserts, so first fetch is cycle 2).
//   RUN -> FLUSH on redirect_valid; FLUSH -> RUN after exactly 1 cycle (redirect in FLUSH restarts FLUSH).
//  imem_valid = (state==RUN) & !fifo_full. fifo_full uses count BEFORE this cycle's pop (no push when full,
//   even with a simultaneous pop).
//  fire = imem_valid & imem_ready & !stall & !redirect_valid.
//  On fire: push {pc, pt, nxt, pred_idx}; pc <= nxt, where pt = pred_hit & pred_taken,
//   nxt = pt ? {pred_target[XLEN-1:2],2'b00} : pc+4 (mod 2^XLEN; 32'hFFFF_FFFC+4 -> 0).
//  No fire: pc holds. Predictor inputs are ignored when not firing.
//  redirect_valid (any state, highest priority): pc <= {redirect_pc[XLEN-1:2],2'b00}; FIFO count<=0,
//   pointers reset; no push, no pop that cycle; meta_valid=0 next cycle.
//  Pop when meta_valid & meta_ready (and no redirect). Push+pop same cycle: count unchanged.
//  meta_* is registered FIFO head; 1-cycle latency fire -> meta_valid. Pointers wrap mod FIFO_DEPTH.
//  Latency: fetch PC update 1 cycle; redirect to new imem_addr 1 cycle, first fetch of it 2 cycles.
//  Reset mid-operation: all state cleared immediately, no partial entries survive.
// STRUCTURE
//  fetch_pkg: fetch_meta_t struct {pc, taken, target, idx}; fetch_state_t enum {IDLE, RUN, FLUSH};
//   localparam INSTR_BYTES = 4.
//  Sub-module pred_meta_fifo (sync FIFO, FIFO_DEPTH x fetch_meta_t, flush input, same clock/reset).
//  Top holds PC register, FSM and next-PC mux only.
// TESTING
//  1 Reset: nrst=0 for 2.4 cycles -> imem_valid=0, imem_addr=0; first fetch cycle 2 after release, PC 0,4,8,...
//  2 Predict taken: at pc=0x10 drive hit=1,taken=1,target=0x103 -> next imem_addr=0x100; meta {0x10,1,0x100,idx}.
//  3 Full FIFO: meta_ready=0, imem_ready=1 -> 4 fetches then imem_valid=0, PC frozen; one pop -> resumes next cycle.
//  4 Redirect with fire+pop pending: redirect_pc=0x200 -> FIFO empty, 1 FLUSH cycle (imem_valid=0), then fetch 0x200.
//  5 Stall/imem_ready=0 for 3 cycles -> PC held, no pushes; wrap test: pc=0xFFFF_FFFC, not taken -> next 0x0.
//  6 Assert nrst=0 mid-run with 3 entries queued -> meta_valid=0, imem_addr=RESET_PC immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, widths and PC alignment helper for the fetch stage.
package fetch_pkg;
    localparam int XLEN        = 32;
    localparam int PHT_IDX_W   = 8;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic                 taken;
        logic [XLEN-1:0]      target;
        logic [PHT_IDX_W-1:0] idx;
    } fetch_meta_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return a & ~XLEN'(INSTR_BYTES - 1);
    endfunction
endpackage

// File: rtl/pred_meta_fifo.sv
// pred_meta_fifo: synchronous FIFO of per-fetch prediction metadata with flush.
module pred_meta_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  fetch_meta_t din_i,
    output logic        full_o,
    output logic        valid_o,
    output fetch_meta_t head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    fetch_meta_t   mem_q [DEPTH];
    logic          do_push, do_pop;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign valid_o = cnt_q != '0;
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & valid_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: fetch PC register, IDLE/RUN/FLUSH control and next-PC selection
// from predictor answers, recording prediction metadata for EX.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic                 sysclk,
    input  logic                 nrst,
    output logic [XLEN-1:0]      imem_addr,
    output logic                 imem_valid,
    input  logic                 imem_ready,
    input  logic                 stall,
    input  logic                 pred_hit,
    input  logic                 pred_taken,
    input  logic [XLEN-1:0]      pred_target,
    input  logic [PHT_IDX_W-1:0] pred_idx,
    input  logic                 redirect_valid,
    input  logic [XLEN-1:0]      redirect_pc,
    output logic                 meta_valid,
    input  logic                 meta_ready,
    output logic [XLEN-1:0]      meta_pc,
    output logic                 meta_taken,
    output logic [XLEN-1:0]      meta_target,
    output logic [PHT_IDX_W-1:0] meta_idx
);
    fetch_state_t    state_q;
    logic [XLEN-1:0] pc_q, pc_d, nxt;
    logic            pt, fire, full;
    fetch_meta_t     head;

    assign pt         = pred_hit & pred_taken;
    assign nxt        = pt ? align_pc(pred_target) : pc_q + XLEN'(INSTR_BYTES);
    assign imem_valid = (state_q == RUN) & ~full;
    assign fire       = imem_valid & imem_ready & ~stall & ~redirect_valid;
    assign pc_d       = redirect_valid ? align_pc(redirect_pc) : fire ? nxt : pc_q;
    assign imem_addr  = pc_q;

    // IDLE always advances to RUN; a redirect arriving in IDLE only retargets the PC
    always_ff @(posedge sysclk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= (state_q == IDLE || !redirect_valid) ? RUN : FLUSH;
            pc_q    <= pc_d;
        end
    end

    pred_meta_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (sysclk),
        .rst_ni  (nrst),
        .push_i  (fire),
        .pop_i   (meta_valid & meta_ready & ~redirect_valid),
        .flush_i (redirect_valid),
        .din_i   ('{pc: pc_q, taken: pt, target: nxt, idx: pred_idx}),
        .full_o  (full),
        .valid_o (meta_valid),
        .head_o  (head)
    );

    assign meta_pc     = head.pc;
    assign meta_taken  = head.taken;
    assign meta_target = head.target;
    assign meta_idx    = head.idx;
endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: directed + random stimulus against a queue-based fetch model with a metadata scoreboard.
module tb_fetch_pc_gen;
    logic        sysclk = 0;
    logic        nrst = 0;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic        imem_ready = 0;
    logic        stall = 0;
    logic        pred_hit = 0;
    logic        pred_taken = 0;
    logic [31:0] pred_target = 0;
    logic [7:0]  pred_idx = 0;
    logic        redirect_valid = 0;
    logic [31:0] redirect_pc = 0;
    logic        meta_valid;
    logic        meta_ready = 0;
    logic [31:0] meta_pc;
    logic        meta_taken;
    logic [31:0] meta_target;
    logic [7:0]  meta_idx;

    always #5 sysclk = ~sysclk;

    fetch_pc_gen dut (
        .sysclk         (sysclk),
        .nrst           (nrst),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_ready     (imem_ready),
        .stall          (stall),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .pred_idx       (pred_idx),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .meta_valid     (meta_valid),
        .meta_ready     (meta_ready),
        .meta_pc        (meta_pc),
        .meta_taken     (meta_taken),
        .meta_target    (meta_target),
        .meta_idx       (meta_idx)
    );

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic [7:0]  idx;
    } exp_t;

    exp_t        sbq[$];
    int          vectors = 0;
    int          miscompares = 0;
    bit          chk_en = 0;
    bit          flushing = 0;
    logic        exp_valid = 0;
    logic [31:0] exp_addr = 0;
    logic [31:0] pc_m = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    // monitor: checks fetch outputs mid-cycle and retires metadata as EX would consume it
    always @(negedge sysclk) begin
        if (chk_en) begin
            chk("imem_valid", 32'(imem_valid), 32'(exp_valid));
            chk("imem_addr", imem_addr, exp_addr);
            chk("meta_valid", 32'(meta_valid), 32'(sbq.size() != 0));
            if (sbq.size() != 0 && meta_ready) begin
                exp_t e;
                e = sbq.pop_front();
                chk("meta_pc", meta_pc, e.pc);
                chk("meta_taken", 32'(meta_taken), 32'(e.taken));
                chk("meta_target", meta_target, e.target);
                chk("meta_idx", 32'(meta_idx), 32'(e.idx));
            end
        end
    end

    task automatic step(input logic rdy, input logic stl, input logic hit, input logic tkn,
                        input logic [31:0] tgt, input logic [7:0] idx, input logic rv,
                        input logic [31:0] rpc, input logic mr);
        logic        fire_m;
        logic [31:0] nxt;
        imem_ready     = rdy;
        stall          = stl;
        pred_hit       = hit;
        pred_taken     = tkn;
        pred_target    = tgt;
        pred_idx       = idx;
        redirect_valid = rv;
        redirect_pc    = rpc;
        meta_ready     = mr;
        exp_valid      = !flushing && sbq.size() < 4;
        exp_addr       = pc_m;
        fire_m         = exp_valid && rdy && !stl && !rv;
        chk_en         = 1;
        @(posedge sysclk);
        #1;
        if (rv) begin
            pc_m = rpc & ~32'd3;
            sbq.delete();
            flushing = 1;
        end else begin
            flushing = 0;
            if (fire_m) begin
                nxt = (hit && tkn) ? (tgt & ~32'd3) : pc_m + 32'd4;
                sbq.push_back('{pc_m, hit && tkn, nxt, idx});
                pc_m = nxt;
            end
        end
    endtask

    task automatic do_reset();
        chk_en = 0;
        nrst = 0;
        imem_ready = 0; stall = 0; pred_hit = 0; pred_taken = 0;
        redirect_valid = 0; meta_ready = 0;
        #1;
        chk("rst_imem_valid", 32'(imem_valid), 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_meta_valid", 32'(meta_valid), 32'd0);
        chk("rst_meta_pc", meta_pc, 32'd0);
        sbq.delete();
        pc_m = 0;
        flushing = 0;
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        #4;
        nrst = 1;
        #0.5;
        chk("idle_imem_valid", 32'(imem_valid), 32'd0);
        @(posedge sysclk);
        #1;
    endtask

    task automatic idle_step(input logic rdy, input logic stl, input logic mr);
        step(rdy, stl, 1'b0, 1'b0, 32'd0, 8'd0, 1'b0, 32'd0, mr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        do_reset();
        repeat (4) idle_step(1, 0, 1);
        step(1, 0, 1, 1, 32'h103, 8'h5A, 0, 0, 0);
        repeat (7) idle_step(1, 0, 0);
        idle_step(1, 0, 1);
        repeat (2) idle_step(1, 0, 0);
        step(1, 0, 1, 1, 32'h77, 8'h11, 1, 32'h203, 1);
        idle_step(1, 0, 1);
        repeat (2) idle_step(1, 0, 1);
        repeat (3) idle_step(1, 1, 1);
        repeat (3) idle_step(0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFE, 1);
        idle_step(1, 0, 1);
        step(1, 0, 1, 0, 32'h500, 8'h3C, 0, 0, 1);
        idle_step(1, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1, 32'h40, 1);
        idle_step(1, 0, 0);
        repeat (3) idle_step(1, 0, 0);
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom,
                     8'($urandom), $urandom_range(0, 19) == 0,
                     ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : $urandom,
                     $urandom_range(0, 2) != 0);
            end
        end
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
